// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Single-issue instruction fetch stage. It walks the program counter, issues
//   one instruction-memory read at a time, and registers the returned word. It
//   presents that word to the decode/control stage with a valid/ready
//   handshake. It also handles control-flow redirects and halt/resume requests.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   imem_req     one-cycle fetch request pulse
//   imem_addr    word address of the request (pc[ADDR_W+1:2])
//   imem_rvalid  read data valid (1..N cycles after imem_req)
//   imem_rdata   instruction word, sampled only with imem_rvalid
//   out_valid    an instruction is being presented
//   out_ready    downstream accepts the presented instruction
//   instr        registered instruction word
//   pc_out       address of the presented instruction
//   op_code      instr[6:2]
//   funct3       instr[14:12]
//   funct7       instr[31:25]
//   redirect     taken branch / jal / jalr: load redirect_pc
//   redirect_pc  redirect target, bits [1:0] ignored
//   halt         stop request pulse
//   resume       leave the halted state
//   halted       high only while halted
//   instr_count  number of completed out handshakes (wraps)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [31:0]       pc_out,
    output logic [4:0]        op_code,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    input  logic              resume,
    output logic              halted,
    output logic [31:0]       instr_count
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_INIT   = RESET_PC & WORD_MASK;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_out_q;
    logic [31:0] instr_q;
    logic        out_valid_q;
    logic        halted_q;
    logic [31:0] count_q;
    logic        discard_q;
    logic        halt_pending_q;

    logic [31:0] target_pc_d;
    logic [31:0] pc_plus4_d;
    logic        handshake_d;

    assign target_pc_d = redirect_pc & WORD_MASK;
    assign pc_plus4_d  = pc_q + 32'd4;
    assign handshake_d = out_valid_q & out_ready;

    // The request is issued in the FETCH cycle itself so a 1-cycle memory
    // gives 3-cycle throughput. A halt or redirect arriving in that same
    // cycle suppresses it: the FSM leaves FETCH without entering WAIT, and a
    // request issued then would still be outstanding when the next fetch is
    // made. Masking with rst keeps the request low while reset is held.
    assign imem_req  = (state_q == S_FETCH) && !rst && !halt && !redirect;
    assign imem_addr = pc_q[ADDR_W+1:2];

    assign out_valid   = out_valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign halted      = halted_q;
    assign instr_count = count_q;
    assign op_code     = instr_q[6:2];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[31:25];

    // Fetch FSM with all registered outputs. A redirect loads the pc in every
    // state, including HALTED and alongside a halt. Without a redirect, only a
    // PRESENT handshake advances the pc. A halt or redirect seen while a read
    // is in flight cannot cancel it. Instead the discard flag drops the
    // returning word. halt_pending_q records whether that drop ends in HALTED
    // or in a fresh FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_FETCH;
            pc_q           <= PC_INIT;
            pc_out_q       <= 32'h0000_0000;
            instr_q        <= NOP_INSTR;
            out_valid_q    <= 1'b0;
            halted_q       <= 1'b0;
            count_q        <= 32'h0000_0000;
            discard_q      <= 1'b0;
            halt_pending_q <= 1'b0;
        end else begin
            if (redirect) begin
                pc_q <= target_pc_d;
            end else if ((state_q == S_PRESENT) && handshake_d) begin
                pc_q <= pc_plus4_d;
            end

            case (state_q)
                S_FETCH: begin
                    if (halt) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end else if (redirect) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q || halt || redirect) begin
                            discard_q      <= 1'b0;
                            halt_pending_q <= 1'b0;
                            if (halt_pending_q || halt) begin
                                state_q  <= S_HALTED;
                                halted_q <= 1'b1;
                            end else begin
                                state_q <= S_FETCH;
                            end
                        end else begin
                            instr_q     <= imem_rdata;
                            pc_out_q    <= pc_q;
                            out_valid_q <= 1'b1;
                            state_q     <= S_PRESENT;
                        end
                    end else begin
                        if (halt || redirect) begin
                            discard_q <= 1'b1;
                        end
                        if (halt) begin
                            halt_pending_q <= 1'b1;
                        end
                    end
                end

                S_PRESENT: begin
                    if (handshake_d) begin
                        count_q <= count_q + 32'd1;
                    end
                    if (halt) begin
                        out_valid_q <= 1'b0;
                        halted_q    <= 1'b1;
                        state_q     <= S_HALTED;
                    end else if (redirect || handshake_d) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_FETCH;
                    end
                end

                S_HALTED: begin
                    if (resume && !halt) begin
                        halted_q <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end

                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Cycle-accurate directed bench for instr_fetch_unit. Each vector row holds
// the inputs for one clock cycle (optionally repeated) and the outputs
// expected in that cycle. Inputs are driven just after the rising edge, and
// outputs are sampled on the falling edge. The instruction memory is modelled
// by the rows themselves: rvalid/rdata appear in the row of the cycle in
// which the word returns.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instr;
    logic [31:0]       pc_out;
    logic [4:0]        op_code;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              halt;
    logic              resume;
    logic              halted;
    logic [31:0]       instr_count;

    int vectorsApplied = 0;
    int miscompares    = 0;
    int vecIdx         = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr       (instr),
        .pc_out      (pc_out),
        .op_code     (op_code),
        .funct3      (funct3),
        .funct7      (funct7),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .resume      (resume),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          reps;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        hlt;
        logic        res;
        logic        eReq;
        logic [9:0]  eAddr;
        logic        eOv;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic        eHalted;
        logic [31:0] eCnt;
    } vec_t;

    function automatic vec_t mk(input int reps, input logic rv, input logic [31:0] rd,
                                input logic rdy, input logic rdr, input logic [31:0] rpc,
                                input logic hl, input logic rs,
                                input logic eReq, input logic [9:0] eAddr, input logic eOv,
                                input logic [31:0] eInstr, input logic [31:0] ePc,
                                input logic eHalted, input logic [31:0] eCnt);
        vec_t v;
        v.reps = reps;   v.rvalid = rv;   v.rdata = rd;    v.ready = rdy;
        v.redir = rdr;   v.rpc = rpc;     v.hlt = hl;      v.res = rs;
        v.eReq = eReq;   v.eAddr = eAddr; v.eOv = eOv;     v.eInstr = eInstr;
        v.ePc = ePc;     v.eHalted = eHalted;              v.eCnt = eCnt;
        return v;
    endfunction

    // Drive one cycle's worth of inputs (called just after a rising edge).
    task automatic applyStimulus(input vec_t v);
        imem_rvalid = v.rvalid;
        imem_rdata  = v.rdata;
        out_ready   = v.ready;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        halt        = v.hlt;
        resume      = v.res;
    endtask

    // Compare every output against the row, right now. The decode fields are
    // expected to be slices of the expected instruction word.
    task automatic compareNow(input vec_t v, input int idx);
        logic [4:0] eOp;
        logic [2:0] eF3;
        logic [6:0] eF7;
        eOp = v.eInstr[6:2];
        eF3 = v.eInstr[14:12];
        eF7 = v.eInstr[31:25];
        vectorsApplied++;
        if (imem_req !== v.eReq || imem_addr !== v.eAddr || out_valid !== v.eOv ||
            instr !== v.eInstr || pc_out !== v.ePc || halted !== v.eHalted ||
            instr_count !== v.eCnt || op_code !== eOp || funct3 !== eF3 || funct7 !== eF7) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got req=%0b addr=%h ov=%0b instr=%h pc=%h halted=%0b cnt=%0d op=%b f3=%b f7=%b; want req=%0b addr=%h ov=%0b instr=%h pc=%h halted=%0b cnt=%0d op=%b f3=%b f7=%b",
                     idx, imem_req, imem_addr, out_valid, instr, pc_out, halted, instr_count,
                     op_code, funct3, funct7, v.eReq, v.eAddr, v.eOv, v.eInstr, v.ePc,
                     v.eHalted, v.eCnt, eOp, eF3, eF7);
        end
    endtask

    // Sample on the falling edge, then step to just after the next rising edge.
    task automatic checkOutput(input vec_t v);
        @(negedge clk);
        compareNow(v, vecIdx);
        vecIdx++;
        @(posedge clk);
        #1;
    endtask

    task automatic runRows(input vec_t rows[$]);
        foreach (rows[i]) begin
            for (int r = 0; r < rows[i].reps; r++) begin
                applyStimulus(rows[i]);
                checkOutput(rows[i]);
            end
        end
    endtask

    // Expected value abbreviations for the table.
    localparam logic [31:0] W0 = 32'h0050_0093;
    localparam logic [31:0] W1 = 32'h00A0_0113;
    localparam logic [31:0] W2 = 32'h0000_0033;
    localparam logic [31:0] W3 = 32'h00B0_0193;
    localparam logic [31:0] W4 = 32'h0000_0073;
    localparam logic [31:0] W5 = 32'h00C0_0213;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    initial begin
        vec_t streamRows[$];
        vec_t recoveryRows[$];
        vec_t resetVec;
        vec_t preReset;

        rst = 1'b1;
        resetVec = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 10'h000, 0, NOP, 32'h0, 0, 0);
        applyStimulus(resetVec);

        // Stream, backpressure, redirect with handshake, redirect in WAIT,
        // halt with handshake, resume.
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h000, 0, NOP, 32'h000, 0, 0));
        streamRows.push_back(mk(1, 1, W0,   1, 0, 0, 0, 0,  0, 10'h000, 0, NOP, 32'h000, 0, 0));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  0, 10'h000, 1, W0,  32'h000, 0, 0));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h001, 0, W0,  32'h000, 0, 1));
        streamRows.push_back(mk(1, 1, W1,   1, 0, 0, 0, 0,  0, 10'h001, 0, W0,  32'h000, 0, 1));
        streamRows.push_back(mk(2, 0, 0,    0, 0, 0, 0, 0,  0, 10'h001, 1, W1,  32'h004, 0, 1));
        streamRows.push_back(mk(1, 1, JUNK, 0, 0, 0, 0, 0,  0, 10'h001, 1, W1,  32'h004, 0, 1));
        streamRows.push_back(mk(2, 0, 0,    0, 0, 0, 0, 0,  0, 10'h001, 1, W1,  32'h004, 0, 1));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  0, 10'h001, 1, W1,  32'h004, 0, 1));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h002, 0, W1,  32'h004, 0, 2));
        streamRows.push_back(mk(1, 1, W2,   1, 0, 0, 0, 0,  0, 10'h002, 0, W1,  32'h004, 0, 2));
        streamRows.push_back(mk(1, 0, 0,    1, 1, 32'h20, 0, 0,  0, 10'h002, 1, W2, 32'h008, 0, 2));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h008, 0, W2,  32'h008, 0, 3));
        streamRows.push_back(mk(1, 0, 0,    1, 1, 32'h103, 0, 0, 0, 10'h008, 0, W2, 32'h008, 0, 3));
        streamRows.push_back(mk(2, 0, 0,    1, 0, 0, 0, 0,  0, 10'h040, 0, W2,  32'h008, 0, 3));
        streamRows.push_back(mk(1, 1, JUNK, 1, 0, 0, 0, 0,  0, 10'h040, 0, W2,  32'h008, 0, 3));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h040, 0, W2,  32'h008, 0, 3));
        streamRows.push_back(mk(1, 1, W3,   1, 0, 0, 0, 0,  0, 10'h040, 0, W2,  32'h008, 0, 3));
        streamRows.push_back(mk(1, 0, 0,    1, 1, 32'h12, 0, 0,  0, 10'h040, 1, W3, 32'h100, 0, 3));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h004, 0, W3,  32'h100, 0, 4));
        streamRows.push_back(mk(1, 1, W4,   1, 0, 0, 0, 0,  0, 10'h004, 0, W3,  32'h100, 0, 4));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 1, 0,  0, 10'h004, 1, W4,  32'h010, 0, 4));
        streamRows.push_back(mk(10, 0, 0,   1, 0, 0, 0, 0,  0, 10'h005, 0, W4,  32'h010, 1, 5));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 1,  0, 10'h005, 0, W4,  32'h010, 1, 5));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h005, 0, W4,  32'h010, 0, 5));
        streamRows.push_back(mk(1, 1, W5,   1, 0, 0, 0, 0,  0, 10'h005, 0, W4,  32'h010, 0, 5));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  0, 10'h005, 1, W5,  32'h014, 0, 5));
        streamRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h006, 0, W5,  32'h014, 0, 6));

        // After the mid-WAIT reset: a stale rvalid in FETCH, halt in WAIT,
        // resume, redirect in FETCH to the top word, and pc wrap to zero.
        recoveryRows.push_back(mk(1, 1, JUNK, 1, 0, 0, 0, 0,  1, 10'h000, 0, NOP, 32'h000, 0, 0));
        recoveryRows.push_back(mk(1, 1, W0,   1, 0, 0, 0, 0,  0, 10'h000, 0, NOP, 32'h000, 0, 0));
        recoveryRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  0, 10'h000, 1, W0,  32'h000, 0, 0));
        recoveryRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h001, 0, W0,  32'h000, 0, 1));
        recoveryRows.push_back(mk(1, 0, 0,    1, 0, 0, 1, 0,  0, 10'h001, 0, W0,  32'h000, 0, 1));
        recoveryRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  0, 10'h001, 0, W0,  32'h000, 0, 1));
        recoveryRows.push_back(mk(1, 1, JUNK, 1, 0, 0, 0, 0,  0, 10'h001, 0, W0,  32'h000, 0, 1));
        recoveryRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  0, 10'h001, 0, W0,  32'h000, 1, 1));
        recoveryRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 1,  0, 10'h001, 0, W0,  32'h000, 1, 1));
        recoveryRows.push_back(mk(1, 0, 0,    1, 1, 32'hFFFF_FFFF, 0, 0, 0, 10'h001, 0, W0, 32'h000, 0, 1));
        recoveryRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h3FF, 0, W0,  32'h000, 0, 1));
        recoveryRows.push_back(mk(1, 1, NOP,  1, 0, 0, 0, 0,  0, 10'h3FF, 0, W0,  32'h000, 0, 1));
        recoveryRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  0, 10'h3FF, 1, NOP, 32'hFFFF_FFFC, 0, 1));
        recoveryRows.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,  1, 10'h000, 0, NOP, 32'hFFFF_FFFC, 0, 2));

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        #1;
        checkOutput(resetVec);
        rst = 1'b0;

        $display("[TB] stream, backpressure, redirect and halt table");
        runRows(streamRows);

        // Now in WAIT for word 6 with no data returned yet. Pull reset between
        // edges and expect the outputs to drop to reset values immediately.
        $display("[TB] asynchronous reset during WAIT");
        preReset = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 10'h006, 0, W5, 32'h014, 0, 6);
        applyStimulus(preReset);
        #2;
        compareNow(preReset, vecIdx);
        vecIdx++;
        rst = 1'b1;
        #1;
        compareNow(resetVec, vecIdx);
        vecIdx++;
        @(posedge clk);
        #1;
        applyStimulus(resetVec);
        checkOutput(resetVec);
        rst = 1'b0;

        $display("[TB] recovery, halt in WAIT, pc wrap");
        runRows(recoveryRows);

        applyStimulus(resetVec);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded by reset, with bits [1:0] forced to 0.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 imem_req  output  1  one-cycle fetch request pulse.
REQ-007 imem_addr  output  ADDR_W  word address, equal to pc[ADDR_W+1:2]; valid while imem_req=1.
REQ-008 imem_rvalid  input  1  read data valid; arrives 1..N cycles after imem_req.
REQ-009 imem_rdata  input  32  instruction word; sampled only when imem_rvalid=1.
REQ-010 out_valid  output  1  a decoded-ready instruction is presented.
REQ-011 out_ready  input  1  the decode/control stage accepts the instruction.
REQ-012 instr  output  32  registered instruction word.
REQ-013 pc_out  output  32  address of the presented instruction.
REQ-014 op_code  output  5  instr[6:2]; funct3  output  3  instr[14:12]; funct7  output  7  instr[31:25]; all combinational from the instr register.
REQ-015 redirect  input  1  taken branch, jal, or jalr; load redirect_pc.
REQ-016 redirect_pc  input  32  target; bits [1:0] ignored and treated as 0.
REQ-017 halt  input  1  ecall-style stop request pulse.
REQ-018 resume  input  1  leave the HALTED state.
REQ-019 halted  output  1  high in the HALTED state only.
REQ-020 instr_count  output  32  count of completed out handshakes; wraps modulo 2^32.

Function
REQ-021 SHALL implement the FSM states FETCH, WAIT, PRESENT, and HALTED, with at most one outstanding memory request.
REQ-022 FETCH: assert imem_req for exactly one cycle with imem_addr from pc, then go to WAIT.
REQ-023 WAIT: on imem_rvalid, register imem_rdata into instr and pc into pc_out, then go to PRESENT; out_valid rises the cycle after imem_rvalid.
REQ-024 PRESENT: hold out_valid=1 and keep instr and pc_out stable until out_valid&out_ready.
REQ-025 On a PRESENT handshake: set pc to pc+4 (wrapping 32'hFFFF_FFFC to 0), increment instr_count, and go to FETCH.
REQ-026 Minimum throughput SHALL be one instruction per 3 cycles: FETCH, then WAIT with 1-cycle memory, then PRESENT with out_ready=1.
REQ-027 Redirect in FETCH or PRESENT: set pc to {redirect_pc[31:2],2'b00}, drop any presented instruction (out_valid=0 next cycle), and go to FETCH.
REQ-028 Redirect in WAIT: set pc to the target and set the discard flag; the next imem_rvalid is dropped and the FSM goes to FETCH.
REQ-029 Redirect together with an out handshake: the handshake counts (instr_count+1) and the next fetch uses redirect_pc, not pc+4.
REQ-030 Halt in FETCH or PRESENT: go to HALTED with out_valid=0 next cycle; a simultaneous handshake still counts; pc becomes pc+4, or redirect_pc if redirect=1.
REQ-031 Halt in WAIT: set the discard flag and go to HALTED once the outstanding imem_rvalid arrives.
REQ-032 HALTED: imem_req=0, out_valid=0, halted=1; redirect still updates pc; resume moves to FETCH.
REQ-033 Priority SHALL be rst > halt > redirect > handshake.
REQ-034 imem_rvalid outside WAIT SHALL be ignored.
REQ-035 imem_req SHALL never be asserted while a request is outstanding.

Reset
REQ-036 While rst=1, the block SHALL hold state=FETCH, pc=RESET_PC, pc_out=0, instr=32'h0000_0013 (nop), out_valid=0, imem_req=0, halted=0, instr_count=0, and discard=0.
REQ-037 The first imem_req SHALL occur in the first cycle after rst deasserts.
REQ-038 Reset in WAIT SHALL abandon the outstanding request, and any later imem_rvalid SHALL be ignored per REQ-034.

Verification
REQ-039 Sequential stream: 1-cycle memory returning 0x00500093 at word 0, out_ready=1 -> out_valid every 3rd cycle, pc_out=0 then 4, op_code=5'b00100, funct3=0, instr_count=1 after the first handshake.
REQ-040 Backpressure: out_ready=0 for 5 cycles in PRESENT -> instr and pc_out stable, no imem_req, and exactly one count after out_ready=1.
REQ-041 Redirect in WAIT: redirect_pc=0x103 during a 4-cycle memory latency -> returned word dropped, next imem_addr=0x40, pc_out=0x100.
REQ-042 Redirect with handshake: both asserted at pc_out=0x8 -> instr_count increments, next pc_out=redirect target (not 0xC).
REQ-043 Halt/resume: halt at pc_out=0x10 with out_ready=1 -> halted=1, no imem_req for 10 cycles; resume -> fetch at 0x14.
REQ-044 Async reset mid-WAIT: rst pulse between clock edges -> outputs go to reset values immediately; the late imem_rvalid is ignored; fetch restarts at RESET_PC.
